// File: rtl/cv32e40p_bit_scanner_if.sv
// Handshake bundle for the set-bit scanner: vector input channel, index output
// channel, flush and a debug view of the scan state.
interface cv32e40p_bit_scanner_if #(
  parameter int LEN = 32
);
  localparam int IDX_W = $clog2(LEN);
  localparam int CNT_W = $clog2(LEN + 1);

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [LEN-1:0]   in_data_i;
  logic             in_dir_i;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic [IDX_W-1:0] idx_o;
  logic             idx_last_o;
  logic             empty_o;
  logic [CNT_W-1:0] cnt_o;
  logic             scan_dbg;

  modport master (
    output flush_i, in_valid_i, in_data_i, in_dir_i, idx_ready_i,
    input  in_ready_o, idx_valid_o, idx_o, idx_last_o, empty_o, cnt_o, scan_dbg
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, in_dir_i, idx_ready_i,
    output in_ready_o, idx_valid_o, idx_o, idx_last_o, empty_o, cnt_o, scan_dbg
  );
endinterface

// File: rtl/cv32e40p_bit_scanner.sv
// Sequential set-bit enumerator: accepts a LEN-bit vector and emits the index of
// every set bit, lowest-first or highest-first, one index per accepted beat.
module cv32e40p_bit_scanner #(
  parameter int LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cv32e40p_bit_scanner_if.slave bus
);
  localparam int IDX_W = $clog2(LEN);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam int P     = 1 << IDX_W;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [LEN-1:0]   pend_q, pend_d, pend_rev;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] lo_idx, hi_raw, cur_idx;
  logic             pend_zero, cur_last, beat, accept, in_ready;

  // Binary find-first-one tree over a power-of-two padded vector; leaf pairs
  // are merged in place, the lower half winning.
  function automatic logic [IDX_W-1:0] ffo_tree(input logic [LEN-1:0] v);
    logic [P-1:0]     vld;
    logic [IDX_W-1:0] idx [P];
    vld = '0;
    vld[LEN-1:0] = v;
    for (int i = 0; i < P; i++) idx[i] = IDX_W'(i);
    for (int w = P; w > 1; w = w / 2) begin
      for (int j = 0; j < w / 2; j++) begin
        idx[j] = vld[2*j] ? idx[2*j] : idx[2*j+1];
        vld[j] = vld[2*j] | vld[2*j+1];
      end
    end
    return idx[0];
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LEN-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LEN; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    pend_rev = '0;
    for (int i = 0; i < LEN; i++) pend_rev[i] = pend_q[LEN-1-i];
  end

  assign pend_zero = (pend_q == '0);
  assign lo_idx    = ffo_tree(pend_q);
  assign hi_raw    = ffo_tree(pend_rev);
  assign cur_idx   = pend_zero ? '0 : (dir_q ? (IDX_W'(LEN - 1) - hi_raw) : lo_idx);
  assign cur_last  = ((pend_q & (pend_q - LEN'(1))) == '0);

  // Both channels transfer on a cycle where valid and ready are high together;
  // valid never waits for ready, and in_ready only looks at idx_ready/flush.
  assign beat     = (state_q == SCAN) & bus.idx_ready_i & ~bus.flush_i;
  assign in_ready = ((state_q == IDLE) | ((state_q == SCAN) & cur_last & bus.idx_ready_i))
                    & ~bus.flush_i;
  assign accept   = bus.in_valid_i & in_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      pend_d  = '0;
      cnt_d   = '0;
    end else begin
      if (beat) begin
        pend_d = pend_q & ~(LEN'(1) << cur_idx);
        if (cur_last) state_d = IDLE;
      end
      // A vector arriving on the final beat replaces the drained pending set.
      if (accept) begin
        state_d = SCAN;
        pend_d  = bus.in_data_i;
        dir_d   = bus.in_dir_i;
        cnt_d   = popcount(bus.in_data_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.idx_valid_o = (state_q == SCAN);
  assign bus.idx_o       = cur_idx;
  assign bus.idx_last_o  = cur_last;
  assign bus.empty_o     = (state_q == SCAN) & (cnt_q == '0);
  assign bus.cnt_o       = cnt_q;
  assign bus.scan_dbg    = (state_q == SCAN);
endmodule

// File: tb/tb_cv32e40p_bit_scanner.sv
// Self-checking bench for cv32e40p_bit_scanner: reset state, table of vectors,
// directed corner sequences, and randomized traffic against a beat-list model.
module tb_cv32e40p_bit_scanner;
  localparam int W = 12;  // {empty, cnt[5:0], idx[4:0]}

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  logic [W-1:0] exp_q[$];

  cv32e40p_bit_scanner_if #(.LEN(32)) bus32 ();
  cv32e40p_bit_scanner_if #(.LEN(5))  bus5 ();

  cv32e40p_bit_scanner #(.LEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  cv32e40p_bit_scanner #(.LEN(5))  dut5  (.clk(clk), .rst(rst), .bus(bus5));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] v, input logic d);
    bus32.in_valid_i = 1'b1;
    bus32.in_data_i  = v;
    bus32.in_dir_i   = d;
    #1;
    chk("send_ready", bus32.in_ready_o, 1'b1);
    tick();
    bus32.in_valid_i = 1'b0;
    #1;
  endtask

  // Reference: list the set-bit indices in the requested order.
  task automatic push_beats(input logic [31:0] v, input logic d);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    if (n == 0) begin
      exp_q.push_back({1'b1, 6'd0, 5'd0});
    end else if (!d) begin
      for (int i = 0; i < 32; i++)
        if (v[i]) exp_q.push_back({1'b0, 6'(n), 5'(i)});
    end else begin
      for (int i = 31; i >= 0; i--)
        if (v[i]) exp_q.push_back({1'b0, 6'(n), 5'(i)});
    end
  endtask

  function automatic logic [31:0] gen_vec();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1, 2:    return 32'h1 << $urandom_range(0, 31);
      3, 4:    return $urandom & $urandom & $urandom;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] data;
    logic        dir;
    int          cnt;
    int          first;
    int          final_idx;
    int          beats;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h0000_0001, 1'b0,  1,  0,  0,  1};
    tbl[1] = '{32'h8000_0000, 1'b1,  1, 31, 31,  1};
    tbl[2] = '{32'hF000_0000, 1'b0,  4, 28, 31,  4};
    tbl[3] = '{32'hF000_0000, 1'b1,  4, 31, 28,  4};
    tbl[4] = '{32'h0000_FFFF, 1'b1, 16, 15,  0, 16};
    tbl[5] = '{32'hAAAA_AAAA, 1'b0, 16,  1, 31, 16};
    tbl[6] = '{32'hFFFF_FFFF, 1'b1, 32, 31,  0, 32};
    tbl[7] = '{32'h0000_0000, 1'b1,  0,  0,  0,  1};
    tbl[8] = '{32'h0001_0100, 1'b0,  2,  8, 16,  2};

    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus32.flush_i = 1'b0; bus32.in_valid_i = 1'b0; bus32.in_data_i = '0;
    bus32.in_dir_i = 1'b0; bus32.idx_ready_i = 1'b1;
    bus5.flush_i = 1'b0; bus5.in_valid_i = 1'b0; bus5.in_data_i = '0;
    bus5.in_dir_i = 1'b0; bus5.idx_ready_i = 1'b1;
    #22;
    rst = 1'b0;
    tick();

    // ---- reset state ----
    chk("rst_in_ready", bus32.in_ready_o, 1'b1);
    chk("rst_valid", bus32.idx_valid_o, 1'b0);
    chk("rst_idx", bus32.idx_o, 0);
    chk("rst_last", bus32.idx_last_o, 1'b1);
    chk("rst_empty", bus32.empty_o, 1'b0);
    chk("rst_cnt", bus32.cnt_o, 0);

    // ---- table-driven vectors, consumer always ready ----
    for (int t = 0; t < 9; t++) begin
      int beats;
      int first;
      int fin;
      bit timed_out;
      beats = 0; first = -1; fin = -1; timed_out = 1'b1;
      send32(tbl[t].data, tbl[t].dir);
      chk("tbl_cnt", bus32.cnt_o, tbl[t].cnt);
      chk("tbl_empty", bus32.empty_o, tbl[t].cnt == 0);
      for (int c = 0; c < 40; c++) begin
        if (!bus32.idx_valid_o) begin
          timed_out = 1'b0;
          break;
        end
        if (beats == 0) first = int'(bus32.idx_o);
        if (bus32.idx_last_o) fin = int'(bus32.idx_o);
        beats++;
        tick();
      end
      chk("tbl_timeout", timed_out, 1'b0);
      chk("tbl_first", first, tbl[t].first);
      chk("tbl_final", fin, tbl[t].final_idx);
      chk("tbl_beats", beats, tbl[t].beats);
    end

    // ---- ascending 0x8000_0011 ----
    send32(32'h8000_0011, 1'b0);
    chk("asc_b0_idx", bus32.idx_o, 0);
    chk("asc_b0_last", bus32.idx_last_o, 1'b0);
    chk("asc_b0_cnt", bus32.cnt_o, 3);
    chk("asc_b0_rdy", bus32.in_ready_o, 1'b0);
    tick();
    chk("asc_b1_idx", bus32.idx_o, 4);
    chk("asc_b1_last", bus32.idx_last_o, 1'b0);
    tick();
    chk("asc_b2_idx", bus32.idx_o, 31);
    chk("asc_b2_last", bus32.idx_last_o, 1'b1);
    chk("asc_b2_cnt", bus32.cnt_o, 3);
    chk("asc_b2_rdy", bus32.in_ready_o, 1'b1);
    tick();
    chk("asc_done_valid", bus32.idx_valid_o, 1'b0);
    chk("asc_done_rdy", bus32.in_ready_o, 1'b1);

    // ---- descending with stalls: ready 1,0,1,0,1 ----
    send32(32'h8000_0011, 1'b1);
    chk("dsc_c0_idx", bus32.idx_o, 31);
    tick(); bus32.idx_ready_i = 1'b0; #1;
    chk("dsc_c1_idx", bus32.idx_o, 4);
    chk("dsc_c1_rdy", bus32.in_ready_o, 1'b0);
    tick(); bus32.idx_ready_i = 1'b1; #1;
    chk("dsc_c2_hold", bus32.idx_o, 4);
    chk("dsc_c2_cnt", bus32.cnt_o, 3);
    tick(); bus32.idx_ready_i = 1'b0; #1;
    chk("dsc_c3_idx", bus32.idx_o, 0);
    chk("dsc_c3_last", bus32.idx_last_o, 1'b1);
    chk("dsc_c3_rdy", bus32.in_ready_o, 1'b0);
    tick(); bus32.idx_ready_i = 1'b1; #1;
    chk("dsc_c4_hold", bus32.idx_o, 0);
    chk("dsc_c4_valid", bus32.idx_valid_o, 1'b1);
    tick();
    chk("dsc_done_valid", bus32.idx_valid_o, 1'b0);

    // ---- all-zero vector ----
    send32(32'h0, 1'b0);
    chk("zero_valid", bus32.idx_valid_o, 1'b1);
    chk("zero_idx", bus32.idx_o, 0);
    chk("zero_empty", bus32.empty_o, 1'b1);
    chk("zero_last", bus32.idx_last_o, 1'b1);
    chk("zero_cnt", bus32.cnt_o, 0);
    tick();
    chk("zero_idle", bus32.scan_dbg, 1'b0);
    chk("zero_done_empty", bus32.empty_o, 1'b0);

    // ---- back-to-back 0x3 then 0x8000_0000 ----
    bus32.in_valid_i = 1'b1; bus32.in_data_i = 32'h3; bus32.in_dir_i = 1'b0;
    tick();
    bus32.in_data_i = 32'h8000_0000;
    #1;
    chk("b2b_idx0", bus32.idx_o, 0);
    chk("b2b_rdy0", bus32.in_ready_o, 1'b0);
    tick();
    chk("b2b_idx1", bus32.idx_o, 1);
    chk("b2b_last1", bus32.idx_last_o, 1'b1);
    chk("b2b_rdy1", bus32.in_ready_o, 1'b1);
    tick();
    bus32.in_valid_i = 1'b0;
    #1;
    chk("b2b_valid2", bus32.idx_valid_o, 1'b1);
    chk("b2b_idx2", bus32.idx_o, 31);
    chk("b2b_cnt2", bus32.cnt_o, 1);
    tick();
    chk("b2b_done", bus32.idx_valid_o, 1'b0);

    // ---- LEN=5, 5'b10110 descending, full run then flush ----
    bus5.in_valid_i = 1'b1; bus5.in_data_i = 5'b10110; bus5.in_dir_i = 1'b1;
    tick(); bus5.in_valid_i = 1'b0; #1;
    chk("l5_b0_idx", bus5.idx_o, 4);
    chk("l5_b0_cnt", bus5.cnt_o, 3);
    tick();
    chk("l5_b1_idx", bus5.idx_o, 2);
    tick();
    chk("l5_b2_idx", bus5.idx_o, 1);
    chk("l5_b2_last", bus5.idx_last_o, 1'b1);
    tick();
    chk("l5_done", bus5.idx_valid_o, 1'b0);
    bus5.in_valid_i = 1'b1;
    tick(); bus5.in_valid_i = 1'b0; #1;
    chk("l5f_b0_idx", bus5.idx_o, 4);
    tick(); bus5.flush_i = 1'b1; #1;
    chk("l5f_b1_idx", bus5.idx_o, 2);
    chk("l5f_rdy_flush", bus5.in_ready_o, 1'b0);
    tick(); bus5.flush_i = 1'b0; #1;
    chk("l5f_valid", bus5.idx_valid_o, 1'b0);
    chk("l5f_cnt", bus5.cnt_o, 0);
    chk("l5f_rdy", bus5.in_ready_o, 1'b1);

    // ---- asynchronous reset mid-scan ----
    send32(32'hFFFF_FFFF, 1'b0);
    tick();
    chk("ar_mid_idx", bus32.idx_o, 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", bus32.idx_valid_o, 1'b0);
    chk("ar_cnt", bus32.cnt_o, 0);
    chk("ar_idx", bus32.idx_o, 0);
    chk("ar_last", bus32.idx_last_o, 1'b1);
    chk("ar_rdy", bus32.in_ready_o, 1'b1);
    rst = 1'b0;
    tick();
    chk("ar_no_beat", bus32.idx_valid_o, 1'b0);
    send32(32'h2, 1'b0);
    chk("ar_new_idx", bus32.idx_o, 1);
    chk("ar_new_last", bus32.idx_last_o, 1'b1);
    tick();
    chk("ar_new_done", bus32.idx_valid_o, 1'b0);

    // ---- randomized traffic against the beat-list model ----
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic         exp_rdy;
      logic         beat;
      logic         acc;
      logic         fl;
      logic [31:0]  v;
      logic         d;
      logic [W-1:0] head;
      v  = gen_vec();
      d  = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 49) == 0);
      bus32.in_valid_i  = ($urandom_range(0, 9) < 6);
      bus32.in_data_i   = v;
      bus32.in_dir_i    = d;
      bus32.idx_ready_i = ($urandom_range(0, 9) < 7);
      bus32.flush_i     = fl;
      #1;
      exp_rdy = !fl && (exp_q.size() == 0 || (exp_q.size() == 1 && bus32.idx_ready_i));
      chk("rnd_rdy", bus32.in_ready_o, exp_rdy);
      chk("rnd_valid", bus32.idx_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("rnd_idx", bus32.idx_o, head[4:0]);
        chk("rnd_cnt", bus32.cnt_o, head[10:5]);
        chk("rnd_empty", bus32.empty_o, head[11]);
        chk("rnd_last", bus32.idx_last_o, exp_q.size() == 1);
      end
      beat = !fl && exp_q.size() != 0 && bus32.idx_ready_i;
      acc  = bus32.in_valid_i && exp_rdy;
      @(posedge clk);
      if (fl) begin
        exp_q.delete();
      end else begin
        if (beat) void'(exp_q.pop_front());
        if (acc) push_beats(v, d);
      end
      #1;
    end
    bus32.in_valid_i  = 1'b0;
    bus32.flush_i     = 1'b0;
    bus32.idx_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      #1;
      chk("drain_idx", bus32.idx_o, exp_q[0][4:0]);
      tick();
      void'(exp_q.pop_front());
    end
    #1;
    chk("drain_done", bus32.idx_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
